// File: rtl/fp32_dot_engine.sv
// Streaming single-precision dot product over (a,b) word pairs, together with the
// combinational fp32_multiplier / fp32_adder it is built from (RNE, denormals flushed to zero).

// Round-to-nearest-even multiply; denormal inputs and underflowing results become signed zero.
module fp32_multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        sign_s, a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s, inc_s;
  logic [47:0] prod_s;
  logic [22:0] mant_s;
  logic [23:0] rnd_s;
  logic [9:0]  exp_s;

  // Mantissa product, one-bit normalisation, rounding and special-value selection.
  always_comb begin
    sign_s   = a[31] ^ b[31];
    a_zero_s = (a[30:23] == 8'd0);
    b_zero_s = (b[30:23] == 8'd0);
    a_inf_s  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf_s  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan_s  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan_s  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    prod_s   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    exp_s    = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (prod_s[47]) begin
      mant_s = prod_s[46:24];
      inc_s  = prod_s[23] & ((|prod_s[22:0]) | prod_s[24]);
      exp_s  = exp_s + 10'd1;
    end else begin
      mant_s = prod_s[45:23];
      inc_s  = prod_s[22] & ((|prod_s[21:0]) | prod_s[23]);
    end
    rnd_s = {1'b0, mant_s} + {23'd0, inc_s};
    exp_s = rnd_s[23] ? (exp_s + 10'd1) : exp_s;
    if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
      y = 32'h7FC0_0000;
    end else if (a_inf_s || b_inf_s) begin
      y = {sign_s, 8'hFF, 23'd0};
    end else if (a_zero_s || b_zero_s || ($signed(exp_s) <= 10'sd0)) begin
      y = {sign_s, 31'd0};
    end else if ($signed(exp_s) >= 10'sd255) begin
      y = {sign_s, 8'hFF, 23'd0};
    end else begin
      y = {sign_s, exp_s[7:0], rnd_s[22:0]};
    end
  end
endmodule

// Round-to-nearest-even add; operands are ordered by magnitude so x always dominates.
module fp32_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0] x_s, z_s;
  logic [23:0] xm_s, zm_s, rnd_s;
  logic [7:0]  d_s;
  logic [49:0] zsh_s;
  logic [26:0] xe_s, ze_s, n_s;
  logic [27:0] sum_s;
  logic [4:0]  lz_s;
  logic [9:0]  exp_s;
  logic        sub_s, inc_s, x_inf_s, z_inf_s, x_nan_s;

  // Align the smaller operand with a sticky bit, add/subtract, renormalise and round.
  always_comb begin
    x_s     = (a[30:0] >= b[30:0]) ? a : b;
    z_s     = (a[30:0] >= b[30:0]) ? b : a;
    sub_s   = x_s[31] ^ z_s[31];
    x_nan_s = (x_s[30:23] == 8'hFF) && (x_s[22:0] != 23'd0);
    x_inf_s = (x_s[30:23] == 8'hFF) && (x_s[22:0] == 23'd0);
    z_inf_s = (z_s[30:23] == 8'hFF) && (z_s[22:0] == 23'd0);
    xm_s    = (x_s[30:23] == 8'd0) ? 24'd0 : {1'b1, x_s[22:0]};
    zm_s    = (z_s[30:23] == 8'd0) ? 24'd0 : {1'b1, z_s[22:0]};
    d_s     = x_s[30:23] - z_s[30:23];
    xe_s    = {xm_s, 3'b000};
    zsh_s   = (d_s > 8'd49) ? 50'd0 : ({zm_s, 26'd0} >> d_s);
    ze_s    = {zsh_s[49:24], (|zsh_s[23:0]) | ((d_s > 8'd49) && (zm_s != 24'd0))};
    sum_s   = sub_s ? ({1'b0, xe_s} - {1'b0, ze_s}) : ({1'b0, xe_s} + {1'b0, ze_s});
    lz_s    = 5'd0;
    for (int i = 0; i < 27; i++) lz_s = sum_s[i] ? 5'(26 - i) : lz_s;
    if (sum_s[27]) begin
      n_s   = {sum_s[27:2], sum_s[1] | sum_s[0]};
      exp_s = {2'b00, x_s[30:23]} + 10'd1;
    end else begin
      n_s   = sum_s[26:0] << lz_s;
      exp_s = {2'b00, x_s[30:23]} - {5'd0, lz_s};
    end
    inc_s = n_s[2] & (n_s[1] | n_s[0] | n_s[3]);
    rnd_s = {1'b0, n_s[25:3]} + {23'd0, inc_s};
    exp_s = rnd_s[23] ? (exp_s + 10'd1) : exp_s;
    if (x_nan_s || (x_inf_s && z_inf_s && sub_s)) begin
      y = 32'h7FC0_0000;
    end else if (x_inf_s) begin
      y = {x_s[31], 8'hFF, 23'd0};
    end else if (x_s[30:23] == 8'd0) begin
      y = {x_s[31] & z_s[31], 31'd0};
    end else if (!n_s[26]) begin
      y = 32'd0;
    end else if ($signed(exp_s) >= 10'sd255) begin
      y = {x_s[31], 8'hFF, 23'd0};
    end else if ($signed(exp_s) <= 10'sd0) begin
      y = {x_s[31], 31'd0};
    end else begin
      y = {x_s[31], exp_s[7:0], rnd_s[22:0]};
    end
  end
endmodule

module fp32_dot_engine #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [31:0]      DATA_I,
  input  logic             IN_VALID_I,
  output logic             IN_READY_O,
  input  logic [LEN_W-1:0] LEN_I,
  input  logic             ACC_MODE_I,
  output logic [31:0]      RESULT_O,
  output logic             OUT_VALID_O,
  input  logic             OUT_READY_I,
  output logic [LEN_W-1:0] PAIR_CNT_O,
  output logic             LEN_ERR_O
);
  typedef enum logic [2:0] {IDLE, LD_ACC, LD_A, LD_B, DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  state_t           state_r;
  logic [31:0]      acc_r, a_r, result_r, prod_s, sum_s;
  logic [LEN_W-1:0] len_r, pair_cnt_r, len_clamp_s, pair_nxt_s;
  logic             in_ready_r, out_valid_r, len_err_r, xfer_s, len_ovf_s;

  fp32_multiplier u_mul (.a(a_r),   .b(DATA_I), .y(prod_s));
  fp32_adder      u_add (.a(acc_r), .b(prod_s), .y(sum_s));

  // Handshake qualifier and frame-start length clamp.
  always_comb begin
    xfer_s      = IN_VALID_I & in_ready_r;
    len_ovf_s   = (LEN_I > MAX_LEN_C);
    len_clamp_s = len_ovf_s ? MAX_LEN_C : LEN_I;
    pair_nxt_s  = pair_cnt_r + LEN_W'(1);
  end

  // Frame sequencer; ready/valid are registered so they line up with the state they describe.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_r     <= IDLE;
      acc_r       <= 32'd0;
      a_r         <= 32'd0;
      result_r    <= 32'd0;
      len_r       <= '0;
      pair_cnt_r  <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      len_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (xfer_s) begin
            len_r      <= len_clamp_s;
            len_err_r  <= len_err_r | len_ovf_s;
            pair_cnt_r <= '0;
            if (ACC_MODE_I) begin
              acc_r <= DATA_I;
              if (len_clamp_s == '0) begin
                state_r     <= DONE;
                result_r    <= DATA_I;
                out_valid_r <= 1'b1;
                in_ready_r  <= 1'b0;
              end else begin
                state_r <= LD_A;
              end
            end else begin
              acc_r <= 32'd0;
              if (len_clamp_s == '0) begin
                state_r     <= DONE;
                result_r    <= 32'd0;
                out_valid_r <= 1'b1;
                in_ready_r  <= 1'b0;
              end else begin
                a_r     <= DATA_I;
                state_r <= LD_B;
              end
            end
          end
        end
        // Not entered: the initial accumulator word is absorbed by the frame-start transfer.
        LD_ACC: begin
          in_ready_r <= 1'b1;
          if (xfer_s) begin
            acc_r   <= DATA_I;
            state_r <= LD_A;
          end
        end
        LD_A: begin
          in_ready_r <= 1'b1;
          if (xfer_s) begin
            a_r     <= DATA_I;
            state_r <= LD_B;
          end
        end
        LD_B: begin
          in_ready_r <= 1'b1;
          if (xfer_s) begin
            acc_r      <= sum_s;
            pair_cnt_r <= pair_nxt_s;
            if (pair_nxt_s == len_r) begin
              state_r     <= DONE;
              result_r    <= sum_s;
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
            end else begin
              state_r <= LD_A;
            end
          end
        end
        DONE: begin
          if (OUT_READY_I) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            pair_cnt_r  <= '0;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY_O  = in_ready_r;
  assign OUT_VALID_O = out_valid_r;
  assign RESULT_O    = result_r;
  assign PAIR_CNT_O  = pair_cnt_r;
  assign LEN_ERR_O   = len_err_r;
endmodule

// File: tb/tb_fp32_dot_engine.sv
// Randomised frame-level bench for fp32_dot_engine; expected results come from real-number
// arithmetic rounded to single precision, with operand exponents kept in a range where that is exact.
module tb_fp32_dot_engine;
  localparam int MAX_LEN = 4;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      data;
  logic             in_valid;
  logic             in_ready;
  logic [LEN_W-1:0] len;
  logic             acc_mode;
  logic [31:0]      result;
  logic             out_valid;
  logic             out_ready;
  logic [LEN_W-1:0] pair_cnt;
  logic             len_err;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic        err_model = 1'b0;
  logic [31:0] wq[$];

  fp32_dot_engine #(.MAX_LEN(MAX_LEN)) dut (
    .CLK_I(clk), .RST_I(rst), .DATA_I(data), .IN_VALID_I(in_valid), .IN_READY_O(in_ready),
    .LEN_I(len), .ACC_MODE_I(acc_mode), .RESULT_O(result), .OUT_VALID_O(out_valid),
    .OUT_READY_I(out_ready), .PAIR_CNT_O(pair_cnt), .LEN_ERR_O(len_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [52:0] m;
    logic [24:0] keep;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e    = int'(d[62:52]) - 896;
    m    = {1'b1, d[51:0]};
    keep = {1'b0, m[52:29]};
    if (m[28] && ((|m[27:0]) || m[29])) keep = keep + 25'd1;
    if (keep[24]) begin
      e    = e + 1;
      keep = keep >> 1;
    end
    return {d[63], 8'(e), keep[22:0]};
  endfunction

  function automatic logic [31:0] rand_f32();
    return {1'($urandom), 8'($urandom_range(130, 124)), 23'($urandom)};
  endfunction

  task automatic send_word(input logic [31:0] w, input logic [LEN_W-1:0] l, input logic m);
    int n;
    n        = 0;
    data     = w;
    len      = l;
    acc_mode = m;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) check_eq("in_ready_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    data     = $urandom;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_pair_cnt", pair_cnt, 0);
    check_eq("rst_len_err", len_err, 0);
    rst       = 1'b0;
    err_model = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_release_ready", in_ready, 1);
  endtask

  task automatic run_frame(input logic mode, input int len_req, input int hold, input logic early,
                           input int gap_max, input logic use_dir, input logic [31:0] dir_res);
    int          leff, nw, base;
    logic [31:0] acc, prod;
    logic [31:0] words[$];
    leff = (len_req > MAX_LEN) ? MAX_LEN : len_req;
    if (len_req > MAX_LEN) err_model = 1'b1;
    nw = mode ? (1 + 2 * leff) : ((leff == 0) ? 1 : 2 * leff);
    while (wq.size() < nw) wq.push_back(rand_f32());
    words = wq;
    wq.delete();
    base = mode ? 1 : 0;
    acc  = mode ? words[0] : 32'd0;
    for (int p = 0; p < leff; p++) begin
      prod = r2f(f2r(words[base + 2 * p]) * f2r(words[base + 2 * p + 1]));
      acc  = r2f(f2r(acc) + f2r(prod));
    end
    out_ready = early;
    for (int k = 0; k < nw; k++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        @(posedge clk); #1;
      end
      if (k == 0) send_word(words[k], LEN_W'(len_req), mode);
      else send_word(words[k], LEN_W'($urandom), 1'($urandom));
      if (k < nw - 1) begin
        check_eq("no_early_valid", out_valid, 0);
        check_eq("in_ready_mid", in_ready, 1);
        if (k >= base && ((k - base) % 2) == 1) check_eq("pair_cnt_mid", pair_cnt, (k - base + 1) / 2);
      end
    end
    check_eq("out_valid_latency", out_valid, 1);
    check_eq("in_ready_done", in_ready, 0);
    check_eq("result", result, acc);
    check_eq("pair_cnt_final", pair_cnt, leff);
    check_eq("len_err", len_err, err_model);
    if (use_dir) check_eq("directed_result", result, dir_res);
    out_ready = 1'b0;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_result", result, acc);
      check_eq("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("post_out_valid", out_valid, 0);
    check_eq("post_in_ready", in_ready, 1);
    check_eq("post_pair_cnt", pair_cnt, 0);
  endtask

  initial begin
    rst       = 1'b1;
    data      = 32'd0;
    in_valid  = 1'b0;
    len       = '0;
    acc_mode  = 1'b0;
    out_ready = 1'b0;
    do_reset(3);

    // 1*2 + 3*4 with OUT_READY already high, then the same with a 0.5 initial accumulator.
    wq = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    run_frame(1'b0, 2, 0, 1'b1, 0, 1'b1, 32'h4160_0000);
    wq = '{32'h3F00_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    run_frame(1'b1, 2, 10, 1'b0, 0, 1'b1, 32'h4168_0000);

    // Zero-length frames in both accumulator modes.
    wq = '{32'h40A0_0000};
    run_frame(1'b1, 0, 2, 1'b0, 0, 1'b1, 32'h40A0_0000);
    run_frame(1'b0, 0, 1, 1'b0, 0, 1'b1, 32'h0000_0000);

    // Over-long request runs MAX_LEN pairs and leaves the error flag set for later frames.
    run_frame(1'b0, 7, 0, 1'b0, 1, 1'b0, 32'd0);
    run_frame(1'b1, 1, 0, 1'b0, 0, 1'b0, 32'd0);

    // Abort a frame after three transfers, then a clean 2*3 frame.
    send_word(32'h3F80_0000, LEN_W'(3), 1'b0);
    send_word(32'h4000_0000, LEN_W'(0), 1'b1);
    send_word(32'h4040_0000, LEN_W'(0), 1'b0);
    do_reset(1);
    wq = '{32'h4000_0000, 32'h4040_0000};
    run_frame(1'b0, 1, 0, 1'b0, 0, 1'b1, 32'h40C0_0000);

    for (int f = 0; f < 40; f++) begin
      run_frame(1'($urandom), $urandom_range(7, 0), $urandom_range(3, 0), 1'($urandom),
                $urandom_range(2, 0), 1'b0, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fp32_dot_engine.md
FP32_DOT_ENGINE -- requirements
Module: fp32_dot_engine

Interface
REQ-001 SHALL have parameter MAX_LEN, 16: maximum number of (a,b) pairs per frame, legal range 1..255.
REQ-002 SHALL have parameter LEN_W, $clog2(MAX_LEN+1): width of LEN_I and PAIR_CNT_O.
REQ-003 SHALL have port CLK_I  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_I  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port DATA_I  input  32: IEEE-754 single-precision operand word.
REQ-006 SHALL have port IN_VALID_I  input  1: DATA_I is valid.
REQ-007 SHALL have port IN_READY_O  output  1: block accepts DATA_I this cycle.
REQ-008 SHALL have port LEN_I  input  LEN_W: pair count for the next frame, sampled at frame start.
REQ-009 SHALL have port ACC_MODE_I  input  1: sampled at frame start. 1 = first word of the frame is the initial accumulator. 0 = accumulator starts at +0.0 (0x00000000).
REQ-010 SHALL have port RESULT_O  output  32: final dot-product result.
REQ-011 SHALL have port OUT_VALID_O  output  1: RESULT_O is valid.
REQ-012 SHALL have port OUT_READY_I  input  1: downstream accepts RESULT_O.
REQ-013 SHALL have port PAIR_CNT_O  output  LEN_W: pairs accumulated so far in the current frame.
REQ-014 SHALL have port LEN_ERR_O  output  1: sticky flag, set when a frame started with LEN_I > MAX_LEN.

Function
REQ-015 SHALL implement FSM states IDLE, LD_ACC, LD_A, LD_B, DONE.
REQ-016 A transfer SHALL occur only on a cycle where IN_VALID_I && IN_READY_O; no other cycle SHALL change operand state.
REQ-017 IN_READY_O SHALL be 1 in IDLE, LD_ACC, LD_A and LD_B, and 0 in DONE.
REQ-018 Frame start is the first transfer in IDLE. On that transfer the block SHALL latch LEN_I (clamped to MAX_LEN) and ACC_MODE_I.
REQ-019 If ACC_MODE_I=1, the frame-start word SHALL be loaded into the accumulator and the FSM SHALL go to LD_A, or to DONE if the latched length is 0.
REQ-020 If ACC_MODE_I=0, the accumulator SHALL be set to 0x00000000, the frame-start word SHALL be taken as operand a, and the FSM SHALL go to LD_B.
REQ-021 If ACC_MODE_I=0 and the latched length is 0, the frame-start word SHALL be discarded, RESULT_O SHALL be 0x00000000, and the FSM SHALL go to DONE.
REQ-022 LD_A transfer: register operand a, then go to LD_B.
REQ-023 LD_B transfer: acc <= fp32_add(acc, fp32_mul(a, DATA_I)), built from the library fp32_multiplier and fp32_adder (combinational). PAIR_CNT_O SHALL increment by 1.
REQ-024 After an LD_B transfer the FSM SHALL go to LD_A, or to DONE when PAIR_CNT reaches the latched length.
REQ-025 One pair SHALL be accepted every 2 cycles at most; there SHALL be no bubble inserted by the block.
REQ-026 OUT_VALID_O SHALL rise the cycle after the final LD_B transfer (latency 1 cycle).
REQ-027 In DONE, OUT_VALID_O=1 and RESULT_O SHALL hold the accumulator, both stable until OUT_READY_I=1.
REQ-028 On OUT_VALID_O && OUT_READY_I the FSM SHALL return to IDLE and PAIR_CNT_O SHALL clear to 0; IN_READY_O SHALL be 1 on the following cycle.
REQ-029 OUT_READY_I SHALL be ignored outside DONE.
REQ-030 LEN_I and ACC_MODE_I SHALL be ignored outside the frame-start transfer; changes mid-frame SHALL have no effect.
REQ-031 LEN_ERR_O SHALL set on a frame start with LEN_I > MAX_LEN and SHALL clear only on reset; the frame SHALL still run with MAX_LEN pairs.
REQ-032 Special values (NaN, Inf, denormals) SHALL propagate exactly as the library adder/multiplier produce them; the block SHALL apply no extra handling.

Reset
REQ-033 While RST_I=1 at a clock edge: FSM=IDLE, accumulator=0, operand a=0, PAIR_CNT_O=0, OUT_VALID_O=0, RESULT_O=0x00000000, LEN_ERR_O=0.
REQ-034 IN_READY_O SHALL be 0 during reset and 1 on the first cycle after RST_I deasserts.
REQ-035 Reset asserted mid-frame or in DONE SHALL abort the frame; no result SHALL be emitted for it.

Verification
REQ-036 LEN_I=2, ACC_MODE_I=0, words 0x3F800000, 0x40000000, 0x40400000, 0x40800000, OUT_READY_I=1 -> RESULT_O=0x41600000 (14.0), OUT_VALID_O high 1 cycle after the 4th transfer, PAIR_CNT_O=2.
REQ-037 Same data preceded by acc word 0x3F000000, ACC_MODE_I=1 -> RESULT_O=0x41680000 (14.5).
REQ-038 OUT_READY_I held 0 for 10 cycles in DONE -> RESULT_O and OUT_VALID_O stable, IN_READY_O=0 throughout; back-to-back next frame accepted the cycle after the handshake.
REQ-039 LEN_I=0: with ACC_MODE_I=1 and word 0x40A00000 -> RESULT_O=0x40A00000; with ACC_MODE_I=0 -> RESULT_O=0x00000000.
REQ-040 MAX_LEN=4, LEN_I=7 -> LEN_ERR_O=1 and exactly 4 pairs consumed; LEN_ERR_O persists into the next frame.
REQ-041 RST_I pulsed after 3 transfers, then a clean LEN_I=1 frame 0x40000000 x 0x40400000 -> RESULT_O=0x40C00000 (6.0), with no stale result emitted before it.
